// File: rtl/hf_pkg.sv
// hf_pkg: shared constants for the HF reader path.
// Holds the datapath mode words, the reader sequencer state encoding,
// default guard/silence lengths and a saturating counter helper.
package hf_pkg;

    // Mode words understood by the HF modulation/demodulation datapath
    localparam logic [2:0] SNIFFER       = 3'b000;
    localparam logic [2:0] TAGSIM_LISTEN = 3'b001;
    localparam logic [2:0] TAGSIM_MOD    = 3'b010;
    localparam logic [2:0] READER_LISTEN = 3'b011;
    localparam logic [2:0] READER_MOD    = 3'b100;

    // Default bit-period counts for the reader sequencer
    localparam int GUARD_TICKS_DEF   = 8;
    localparam int SILENCE_TICKS_DEF = 4;

    // Reader transaction sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX      = 3'd1,
        ST_GUARD   = 3'd2,
        ST_WAIT_RX = 3'd3,
        ST_RX      = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
    endfunction

endpackage

// File: rtl/hf_bit_timer.sv
// hf_bit_timer: 16-bit loadable down-counter in bit periods.
// Load has priority over the tick; the count stops at zero.
module hf_bit_timer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic        i_tick,
    output logic [15:0] o_count,
    output logic        o_zero
);

    logic [15:0] r_count;

    // Reload on request, otherwise count one bit period down per tick
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 16'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick && (r_count != 16'd0)) begin
            r_count <= r_count - 16'd1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == 16'd0);

endmodule

// File: rtl/hf_reader_seq.sv
// hf_reader_seq: sequences one ISO14443-A reader transaction
// (modulate, guard, wait for tag, receive, finish) and drives the
// 3-bit datapath mode word. All logic runs on negedge osc_clk.
// Optional: define HF_READER_SEQ_TICKGEN_EN to derive bit_tick from an
// internal 16-cycle counter; the bit_tick port is then ignored.
module hf_reader_seq
    import hf_pkg::*;
#(
    parameter int         GUARD_TICKS   = GUARD_TICKS_DEF,
    parameter int         SILENCE_TICKS = SILENCE_TICKS_DEF,
    parameter logic [2:0] IDLE_MODE     = READER_LISTEN
) (
    input  logic        osc_clk,
    input  logic        nrst,
    input  logic        bit_tick,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] tx_len,
    input  logic [15:0] timeout_len,
    input  logic        curbit,
    output logic [2:0]  mod_type,
    output logic        busy,
    output logic        done,
    output logic        timed_out,
    output logic [15:0] rx_len
);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    logic        w_tick;
    logic        w_accept;

    logic        w_tmr_load;
    logic [15:0] w_tmr_val;
    logic [15:0] w_tmr_cnt;
    logic        w_tmr_zero;
    logic        w_tmr_last;

    logic [15:0] r_to_len;
    logic [15:0] r_prov;
    logic [2:0]  r_mod_type;
    logic        r_busy;
    logic        r_done;
    logic        r_timed_out;
    logic [15:0] r_rx_len;

    logic [15:0] w_to_len_nxt;
    logic [15:0] w_prov_nxt;
    logic [2:0]  w_mod_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_to_nxt;
    logic [15:0] w_rx_len_nxt;

`ifdef HF_READER_SEQ_TICKGEN_EN
    logic [3:0] r_tick_cnt;

    // Free-running divider: one tick per 16 carrier cycles, first after 16
    always_ff @(negedge osc_clk or negedge nrst) begin
        if (!nrst) begin
            r_tick_cnt <= 4'd0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
        end
    end

    assign w_tick = (r_tick_cnt == 4'd15);
`else
    assign w_tick = bit_tick;
`endif

    // Abort beats a simultaneous start, so a start is only taken alone
    assign w_accept = (r_state == ST_IDLE) && start && !abort;

    // The tick seen with the counter at 1 is the last one of the phase
    assign w_tmr_last = w_tmr_zero || (w_tmr_cnt == 16'd1);

    hf_bit_timer u_timer (
        .i_clk      (osc_clk),
        .i_rst_n    (nrst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_tick     (w_tick),
        .o_count    (w_tmr_cnt),
        .o_zero     (w_tmr_zero)
    );

    // State register
    always_ff @(negedge osc_clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and timer reload; loading on the transition cycle means a
    // tick in that same cycle is never counted by the new phase
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = 16'd0;
        if ((r_state != ST_IDLE) && abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_tmr_load = 1'b1;
                        if (tx_len == 12'd0) begin
                            w_state_nxt = ST_GUARD;
                            w_tmr_val   = 16'(GUARD_TICKS);
                        end else begin
                            w_state_nxt = ST_TX;
                            w_tmr_val   = {4'd0, tx_len};
                        end
                    end
                end
                ST_TX: begin
                    if (w_tick && w_tmr_last) begin
                        w_state_nxt = ST_GUARD;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = 16'(GUARD_TICKS);
                    end
                end
                ST_GUARD: begin
                    if (w_tick && w_tmr_last) begin
                        w_state_nxt = ST_WAIT_RX;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = r_to_len;
                    end
                end
                ST_WAIT_RX: begin
                    if (w_tick) begin
                        if (curbit) begin
                            w_state_nxt = ST_RX;
                            w_tmr_load  = 1'b1;
                            w_tmr_val   = 16'(SILENCE_TICKS);
                        end else if ((r_to_len != 16'd0) && w_tmr_last) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_RX: begin
                    if (w_tick) begin
                        if (curbit) begin
                            w_tmr_load = 1'b1;
                            w_tmr_val  = 16'(SILENCE_TICKS);
                        end else if (w_tmr_last) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Output comb: next values of the registered outputs and result data
    always_comb begin
        w_mod_nxt    = (w_state_nxt == ST_TX)   ? READER_MOD :
                       (w_state_nxt == ST_IDLE) ? IDLE_MODE  : READER_LISTEN;
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
        w_done_nxt   = (w_state_nxt == ST_DONE);
        w_to_nxt     = r_timed_out;
        w_rx_len_nxt = r_rx_len;
        w_prov_nxt   = r_prov;
        w_to_len_nxt = r_to_len;
        if (w_accept) begin
            w_to_nxt     = 1'b0;
            w_rx_len_nxt = 16'd0;
            w_to_len_nxt = timeout_len;
        end
        if ((r_state == ST_WAIT_RX) && (w_state_nxt == ST_DONE)) begin
            w_to_nxt = 1'b1;
        end
        if ((r_state == ST_WAIT_RX) && (w_state_nxt == ST_RX)) begin
            w_rx_len_nxt = 16'd1;
            w_prov_nxt   = 16'd1;
        end
        if ((r_state == ST_RX) && (w_state_nxt != ST_IDLE) && w_tick) begin
            w_prov_nxt = sat_inc16(r_prov);
            if (curbit) begin
                w_rx_len_nxt = sat_inc16(r_prov);
            end
        end
    end

    // Output and result registers
    always_ff @(negedge osc_clk or negedge nrst) begin
        if (!nrst) begin
            r_mod_type  <= IDLE_MODE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
            r_rx_len    <= 16'd0;
            r_prov      <= 16'd0;
            r_to_len    <= 16'd0;
        end else begin
            r_mod_type  <= w_mod_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_timed_out <= w_to_nxt;
            r_rx_len    <= w_rx_len_nxt;
            r_prov      <= w_prov_nxt;
            r_to_len    <= w_to_len_nxt;
        end
    end

    assign mod_type  = r_mod_type;
    assign busy      = r_busy;
    assign done      = r_done;
    assign timed_out = r_timed_out;
    assign rx_len    = r_rx_len;

endmodule
